// File: rtl/tvm_buffer_pkg.sv
// Shared definitions for the tvm_buffer writer: FSM state encoding and
// default command field widths.
package tvm_buffer_pkg;

  localparam int unsigned CMD_DATA_WIDTH = 8;
  localparam int unsigned CMD_LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } wr_state_e;

endpackage

// File: rtl/tvm_buffer_writer_if.sv
// Command and write-port bundle between the burst writer and its environment.
// The master modport is the writer's view; slave is the environment's view.
interface tvm_buffer_writer_if
  import tvm_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = CMD_DATA_WIDTH,
  parameter int LEN_WIDTH     = CMD_LEN_WIDTH,
  parameter int WR_ADDR_WIDTH = 1
);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [DATA_WIDTH-1:0]    cmd_base;
  logic [DATA_WIDTH-1:0]    cmd_stride;
  logic [LEN_WIDTH-1:0]     cmd_len;
  logic                     write_valid;
  logic                     write_ready;
  logic                     write_advance;
  logic [WR_ADDR_WIDTH-1:0] write_addr;
  logic [DATA_WIDTH-1:0]    write_data;
  logic                     busy;
  logic                     done;

  modport master (
    input  cmd_valid, cmd_base, cmd_stride, cmd_len, write_ready,
    output cmd_ready, write_valid, write_advance, write_addr, write_data,
           busy, done
  );

  modport slave (
    output cmd_valid, cmd_base, cmd_stride, cmd_len, write_ready,
    input  cmd_ready, write_valid, write_advance, write_addr, write_data,
           busy, done
  );

endinterface

// File: rtl/tvm_buffer_writer_stride_gen.sv
// Word generator: data accumulator, window offset and remaining-word counter.
// Flags for the word currently presented are precomputed one step ahead.
module tvm_stride_gen
  import tvm_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = CMD_DATA_WIDTH,
  parameter int LEN_WIDTH     = CMD_LEN_WIDTH,
  parameter int WR_WINDOW     = 1,
  parameter int WR_ADDR_WIDTH = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     load,
  input  logic                     step,
  input  logic [DATA_WIDTH-1:0]    base,
  input  logic [DATA_WIDTH-1:0]    stride,
  input  logic [LEN_WIDTH-1:0]     len,
  output logic [DATA_WIDTH-1:0]    data,
  output logic [WR_ADDR_WIDTH-1:0] addr,
  output logic                     advance,
  output logic                     last
);

  localparam logic [WR_ADDR_WIDTH-1:0] ADDR_ZERO = {WR_ADDR_WIDTH{1'b0}};
  localparam logic [WR_ADDR_WIDTH-1:0] ADDR_ONE  = WR_ADDR_WIDTH'(1);
  localparam logic [WR_ADDR_WIDTH-1:0] ADDR_LAST = WR_ADDR_WIDTH'(WR_WINDOW - 1);
  localparam logic [LEN_WIDTH-1:0]     LEN_ONE   = LEN_WIDTH'(1);
  localparam logic [LEN_WIDTH-1:0]     LEN_TWO   = LEN_WIDTH'(2);

  logic [DATA_WIDTH-1:0]    acc_r;
  logic [DATA_WIDTH-1:0]    stride_r;
  logic [LEN_WIDTH-1:0]     remain_r;
  logic [WR_ADDR_WIDTH-1:0] addr_r;
  logic                     adv_r;
  logic                     last_r;
  logic [WR_ADDR_WIDTH-1:0] addr_nxt_s;

  // Next window offset, wrapping at the end of the window
  always_comb begin
    addr_nxt_s = ADDR_ZERO;
    if (addr_r == ADDR_LAST) begin
      addr_nxt_s = ADDR_ZERO;
    end else begin
      addr_nxt_s = addr_r + ADDR_ONE;
    end
  end

  // Accumulator, offset and down-counter; remain counts words still to send
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r    <= {DATA_WIDTH{1'b0}};
      stride_r <= {DATA_WIDTH{1'b0}};
      remain_r <= {LEN_WIDTH{1'b0}};
      addr_r   <= ADDR_ZERO;
      adv_r    <= 1'b0;
      last_r   <= 1'b0;
    end else if (load) begin
      acc_r    <= base;
      stride_r <= stride;
      remain_r <= len;
      addr_r   <= ADDR_ZERO;
      adv_r    <= (ADDR_ZERO == ADDR_LAST) || (len == LEN_ONE);
      last_r   <= (len == LEN_ONE);
    end else if (step) begin
      acc_r    <= acc_r + stride_r;
      remain_r <= remain_r - LEN_ONE;
      addr_r   <= addr_nxt_s;
      adv_r    <= (addr_nxt_s == ADDR_LAST) || (remain_r == LEN_TWO);
      last_r   <= (remain_r == LEN_TWO);
    end else begin
      acc_r    <= acc_r;
      stride_r <= stride_r;
      remain_r <= remain_r;
      addr_r   <= addr_r;
      adv_r    <= adv_r;
      last_r   <= last_r;
    end
  end

  assign data    = acc_r;
  assign addr    = addr_r;
  assign advance = adv_r;
  assign last    = last_r;

endmodule

// File: rtl/tvm_buffer_writer.sv
// Burst writer: turns a (base, stride, len) command into a stream of
// windowed writes toward tvm_buffer, one word per cycle when not stalled.
module tvm_buffer_writer
  import tvm_buffer_pkg::*;
#(
  parameter int DATA_WIDTH    = CMD_DATA_WIDTH,
  parameter int LEN_WIDTH     = CMD_LEN_WIDTH,
  parameter int WR_WINDOW     = 1,
  parameter int WR_ADVANCE    = 1,
  parameter int WR_ADDR_WIDTH = 1
) (
  input logic                 clk,
  input logic                 rst,
  tvm_buffer_writer_if.master bus
);

  if (WR_ADVANCE != WR_WINDOW) begin : g_bad_advance
    $error("tvm_buffer_writer: WR_ADVANCE must equal WR_WINDOW");
  end
  if ((WR_WINDOW < 1) || ((2 ** WR_ADDR_WIDTH) < WR_WINDOW)) begin : g_bad_addr_width
    $error("tvm_buffer_writer: WR_ADDR_WIDTH too small for WR_WINDOW");
  end

  wr_state_e                state_r;
  logic                     cmd_ready_r;
  logic                     write_valid_r;
  logic                     busy_r;
  logic                     done_r;
  logic                     load_s;
  logic                     step_s;
  logic                     last_s;
  logic                     adv_s;
  logic [DATA_WIDTH-1:0]    data_s;
  logic [WR_ADDR_WIDTH-1:0] addr_s;

  // Command handshake and word-transfer strobes for the generator
  always_comb begin
    load_s = 1'b0;
    step_s = 1'b0;
    if (state_r == ST_IDLE) begin
      load_s = bus.cmd_valid & cmd_ready_r;
    end else if (state_r == ST_RUN) begin
      step_s = write_valid_r & bus.write_ready;
    end else begin
      load_s = 1'b0;
      step_s = 1'b0;
    end
  end

  tvm_stride_gen #(
    .DATA_WIDTH    (DATA_WIDTH),
    .LEN_WIDTH     (LEN_WIDTH),
    .WR_WINDOW     (WR_WINDOW),
    .WR_ADDR_WIDTH (WR_ADDR_WIDTH)
  ) u_stride_gen (
    .clk     (clk),
    .rst     (rst),
    .load    (load_s),
    .step    (step_s),
    .base    (bus.cmd_base),
    .stride  (bus.cmd_stride),
    .len     (bus.cmd_len),
    .data    (data_s),
    .addr    (addr_s),
    .advance (adv_s),
    .last    (last_s)
  );

  // Control FSM; cmd_ready stays low during reset and rises on the first edge after
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      cmd_ready_r   <= 1'b0;
      write_valid_r <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          done_r <= 1'b0;
          if (load_s) begin
            cmd_ready_r <= 1'b0;
            if (bus.cmd_len != {LEN_WIDTH{1'b0}}) begin
              state_r       <= ST_RUN;
              write_valid_r <= 1'b1;
              busy_r        <= 1'b1;
            end else begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_RUN: begin
          if (step_s && last_s) begin
            state_r       <= ST_DONE;
            write_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b1;
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DONE: begin
          state_r     <= ST_IDLE;
          done_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r       <= ST_IDLE;
          cmd_ready_r   <= 1'b0;
          write_valid_r <= 1'b0;
          busy_r        <= 1'b0;
          done_r        <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready     = cmd_ready_r;
  assign bus.write_valid   = write_valid_r;
  assign bus.write_advance = write_valid_r & adv_s;
  assign bus.write_addr    = addr_s;
  assign bus.write_data    = data_s;
  assign bus.busy          = busy_r;
  assign bus.done          = done_r;

endmodule
